// File: rtl/seq_mult_pkg.sv
// Shared constants for the sequential shift-add multiplier.
// Holds the FSM state encoding and the default operand width.
package seq_mult_pkg;

    localparam int DEF_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIN  = 2'd2;

    // Number of 4-bit CLA slices needed for a given operand width.
    function automatic int cla_slices(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/cla_add4.sv
// 4-bit generate/propagate carry-lookahead adder slice.
// Ports: A, B (4-bit addends), C0 (carry in) -> S (4-bit sum), C4 (carry out).
module cla_add4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] S,
    output logic       C4
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // All carries are flattened from g/p so no carry ripples inside a slice.
    assign c[0] = C0;
    assign c[1] = g[0] | (p[0] & C0);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & C0);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & C0);
    assign c[4] = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & C0);

    assign S  = p ^ c[3:0];
    assign C4 = c[4];

endmodule

// File: rtl/seq_mult4.sv
// Sequential shift-add unsigned multiplier with START/DONE handshake.
// Ports: clk, rst (async high), START, A, B in; BUSY, DONE, P (2*WIDTH) out.
// Optional macro SEQ_MULT_ZERO_SKIP_EN: zero operands bypass RUN (P=0 in 2 cycles).
module seq_mult4
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] P
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int NSL = cla_slices(WIDTH);

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] p_q;
    logic             done_q;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [NSL:0]     carry;
    logic             c_out;
    logic             last;
    logic             skip;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    assign skip = (A == '0) || (B == '0);
`else
    assign skip = 1'b0;
`endif

    assign addend = q[0] ? m : '0;
    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < NSL; gi++) begin : g_cla
        cla_add4 u_cla (
            .A  (acc[4*gi+3:4*gi]),
            .B  (addend[4*gi+3:4*gi]),
            .C0 (carry[gi]),
            .S  (sum[4*gi+3:4*gi]),
            .C4 (carry[gi+1])
        );
    end

    assign c_out = carry[NSL];
    assign last  = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_d = skip ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Each RUN edge shifts {C,S,Q} right by one; the carry lands in ACC MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m      <= '0;
            acc    <= '0;
            q      <= '0;
            cnt    <= '0;
            p_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_FIN);
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        m   <= A;
                        q   <= B;
                        acc <= '0;
                        cnt <= '0;
                        if (skip) begin
                            p_q <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    acc <= {c_out, sum[WIDTH-1:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        p_q <= {c_out, sum, q[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY = (state == ST_RUN);
    assign DONE = done_q;
    assign P    = p_q;

endmodule

// File: tb/tb_seq_mult4.sv
// Self-checking bench for seq_mult4: directed scenarios plus random
// operands checked against plain integer multiplication and timing rules.
module tb_seq_mult4;
    import seq_mult_pkg::*;

    localparam int W = DEF_WIDTH;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           START = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           BUSY;
    logic           DONE;
    logic [2*W-1:0] P;

    int n_vec = 0;
    int n_err = 0;
    int last_p = 0;

    seq_mult4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .P     (P)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit zero_skip(input int a, input int b);
`ifdef SEQ_MULT_ZERO_SKIP_EN
        return (a == 0) || (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Edges after the START edge until DONE is visible.
    function automatic int exp_lat(input int a, input int b);
        return zero_skip(a, b) ? 1 : W + 1;
    endfunction

    function automatic int exp_busy(input int a, input int b);
        return zero_skip(a, b) ? 0 : W;
    endfunction

    // Call while clk is low; returns at the negedge where DONE is seen.
    task automatic mult(input int a, input int b, input bit inj,
                        input string tag);
        int lat = -1;
        int bz = 0;
        A = W'(a);
        B = W'(b);
        START = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (BUSY) bz++;
            if (i == 0 && !zero_skip(a, b))
                chk({tag, "_hold"}, 32'(P), 32'(last_p));
            if (inj && i == 1) begin
                A = W'(1);
                B = W'(1);
                START = 1'b1;
            end
            if (inj && i == 2) START = 1'b0;
            if (DONE) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, b)));
        chk({tag, "_busy"}, 32'(bz), 32'(exp_busy(a, b)));
        chk({tag, "_p"}, 32'(P), 32'(a * b));
        last_p = a * b;
    endtask

    initial begin
        int a;
        int b;

        repeat (2) @(negedge clk);
        chk("rst_p", 32'(P), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_p", 32'(P), 32'h0);
            chk("idle_done", 32'(DONE), 32'h0);
            chk("idle_busy", 32'(BUSY), 32'h0);
        end

        mult(15, 15, 1'b0, "ff");
        @(negedge clk);
        chk("pulse", 32'(DONE), 32'h0);

        mult(7, 3, 1'b0, "b2b_a");
        mult(9, 5, 1'b0, "b2b_b");
        @(negedge clk);
        chk("hold_idle", 32'(P), 32'h2d);

        mult(0, 9, 1'b0, "zero");
        @(negedge clk);
        chk("zero_pulse", 32'(DONE), 32'h0);

        mult(5, 6, 1'b1, "ign");
        @(negedge clk);
        chk("ign_done", 32'(DONE), 32'h0);
        chk("ign_busy", 32'(BUSY), 32'h0);

        A = 4'hC;
        B = 4'hB;
        START = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_p", 32'(P), 32'h0);
        chk("arst_busy", 32'(BUSY), 32'h0);
        chk("arst_done", 32'(DONE), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("arst_nodone", 32'(DONE), 32'h0);
        end
        rst = 1'b0;
        last_p = 0;
        @(negedge clk);
        mult(2, 3, 1'b0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
            b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
            mult(a, b, 1'b0, "rnd");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rnd_pulse", 32'(DONE), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
